// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the four register-file write ports: buffers up to four
// results per cycle in age order, retires the oldest four, and forwards pending values.

module regfile_wb_queue_chk #(
  parameter int CW    = 4,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count
);
  // Occupancy can never exceed the buffer size.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

module regfile_wb_queue #(
  parameter int WIDTH = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_reg0,
  input  logic [AW-1:0]    in_reg1,
  input  logic [AW-1:0]    in_reg2,
  input  logic [AW-1:0]    in_reg3,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic             wb_stall,
  output logic             we_1,
  output logic             we_2,
  output logic             we_3,
  output logic             we_4,
  output logic [AW-1:0]    write_reg1,
  output logic [AW-1:0]    write_reg2,
  output logic [AW-1:0]    write_reg3,
  output logic [AW-1:0]    write_reg4,
  output logic [WIDTH-1:0] write_reg1_data,
  output logic [WIDTH-1:0] write_reg2_data,
  output logic [WIDTH-1:0] write_reg3_data,
  output logic [WIDTH-1:0] write_reg4_data,
  input  logic [AW-1:0]    fwd_reg1,
  input  logic [AW-1:0]    fwd_reg2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    mem_reg_r  [DEPTH];
  logic [WIDTH-1:0] mem_data_r [DEPTH];
  logic [PW-1:0]    head_r, tail_r;
  logic [CW-1:0]    count_r;
  logic [3:0]       we_r;
  logic [AW-1:0]    out_reg_r  [4];
  logic [WIDTH-1:0] out_data_r [4];

  logic [AW-1:0]    in_reg_s   [4];
  logic [WIDTH-1:0] in_data_s  [4];
  logic [AW-1:0]    fwd_idx_s  [2];
  logic             fwd_hit_s  [2];
  logic [WIDTH-1:0] fwd_data_s [2];
  logic             in_ready_s;
  logic [3:0]       acc_s;
  logic [2:0]       enq_off_s  [4];
  logic [2:0]       n_enq_s, n_deq_s;

  function automatic logic match_f(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return v && (a == b) && (b != {AW{1'b0}});
  endfunction

  assign in_reg_s  = '{in_reg0, in_reg1, in_reg2, in_reg3};
  assign in_data_s = '{in_data0, in_data1, in_data2, in_data3};
  assign fwd_idx_s = '{fwd_reg1, fwd_reg2};

  // Room for a full group is judged on the current count only.
  assign in_ready_s = (count_r <= CW'(DEPTH - 4));

  // Compact accepted channels in channel order; register 0 results are dropped.
  always_comb begin
    acc_s   = 4'b0000;
    n_enq_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      enq_off_s[i] = n_enq_s;
      acc_s[i]     = in_ready_s && in_valid[i] && (in_reg_s[i] != {AW{1'b0}});
      n_enq_s      = n_enq_s + {2'b00, acc_s[i]};
    end
  end

  // Retire up to four oldest entries unless the write ports are borrowed.
  always_comb begin
    if (wb_stall) begin
      n_deq_s = 3'd0;
    end else if (count_r >= CW'(4)) begin
      n_deq_s = 3'd4;
    end else begin
      n_deq_s = count_r[2:0];
    end
  end

  // Oldest-to-youngest scan so the last match is the youngest pending value.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      fwd_hit_s[j]  = 1'b0;
      fwd_data_s[j] = {WIDTH{1'b0}};
      for (int k = 0; k < 4; k++) begin
        fwd_data_s[j] = match_f(we_r[k], out_reg_r[k], fwd_idx_s[j]) ? out_data_r[k] : fwd_data_s[j];
        fwd_hit_s[j]  = fwd_hit_s[j] | match_f(we_r[k], out_reg_r[k], fwd_idx_s[j]);
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_data_s[j] = match_f(CW'(i) < count_r, mem_reg_r[head_r + PW'(i)], fwd_idx_s[j])
                        ? mem_data_r[head_r + PW'(i)] : fwd_data_s[j];
        fwd_hit_s[j]  = fwd_hit_s[j] | match_f(CW'(i) < count_r, mem_reg_r[head_r + PW'(i)], fwd_idx_s[j]);
      end
    end
  end

  // Queue storage; contents outside head..tail are don't-care, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (acc_s[k]) begin
        mem_reg_r[tail_r + PW'(enq_off_s[k])]  <= in_reg_s[k];
        mem_data_r[tail_r + PW'(enq_off_s[k])] <= in_data_s[k];
      end
    end
  end

  // Pointers, occupancy and the registered write-port stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      we_r    <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        out_reg_r[k]  <= {AW{1'b0}};
        out_data_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      head_r  <= head_r + PW'(n_deq_s);
      tail_r  <= tail_r + PW'(n_enq_s);
      count_r <= count_r + CW'(n_enq_s) - CW'(n_deq_s);
      for (int k = 0; k < 4; k++) begin
        if (n_deq_s > 3'(k)) begin
          we_r[k]       <= 1'b1;
          out_reg_r[k]  <= mem_reg_r[head_r + PW'(k)];
          out_data_r[k] <= mem_data_r[head_r + PW'(k)];
        end else begin
          we_r[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready        = in_ready_s;
  assign we_1            = we_r[0];
  assign we_2            = we_r[1];
  assign we_3            = we_r[2];
  assign we_4            = we_r[3];
  assign write_reg1      = out_reg_r[0];
  assign write_reg2      = out_reg_r[1];
  assign write_reg3      = out_reg_r[2];
  assign write_reg4      = out_reg_r[3];
  assign write_reg1_data = out_data_r[0];
  assign write_reg2_data = out_data_r[1];
  assign write_reg3_data = out_data_r[2];
  assign write_reg4_data = out_data_r[3];
  assign fwd_hit1        = fwd_hit_s[0];
  assign fwd_hit2        = fwd_hit_s[1];
  assign fwd_data1       = fwd_data_s[0];
  assign fwd_data2       = fwd_data_s[1];

  regfile_wb_queue_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (count_r)
  );
endmodule
